// File: rtl/hilo_md_unit.sv
// HI/LO register pair with a multi-cycle multiply/divide sequencer.
// One shared 2*WIDTH accumulator runs either shift-add multiply or restoring divide.
module hilo_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             mult,
  input  logic             div,
  input  logic             isUnsigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    CALC  = 2'd2,
    FIXUP = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               is_signed_q, is_signed_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               start;
  logic               abort;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mult_addend;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH:0]     div_upper;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot, rem;

  // Handshake: mult/div are a one-cycle valid; the unit is ready only while
  // busy is low. A start seen while busy is dropped, so the issuer holds it.
  assign start = (mult | div) & ~flush;
  assign abort = (state_q != IDLE) & (flush | hiWrite | loWrite);

  assign a_neg = is_signed_q & opa_q[WIDTH-1];
  assign b_neg = is_signed_q & opb_q[WIDTH-1];
  assign a_mag = a_neg ? -opa_q : opa_q;
  assign b_mag = b_neg ? -opb_q : opb_q;

  // Multiply step: add multiplicand to the upper half when the LSB is set, then shift right.
  assign mult_addend = acc_q[0] ? {1'b0, opb_q} : '0;
  assign mult_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mult_addend;
  assign mult_next   = {mult_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift {rem, dividend} left, keep the trial subtraction when it does not borrow.
  assign div_upper = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_upper - {1'b0, opb_q};
  assign div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign product = neg_res_q ? -acc_q : acc_q;
  assign quot    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PREP;
          is_div_d    = div;
          is_signed_d = ~isUnsigned;
          opa_d       = opA;
          opb_d       = opB;
        end
      end
      PREP: begin
        neg_res_d  = a_neg ^ b_neg;
        neg_rem_d  = a_neg;
        div_zero_d = (opb_q == '0);
        cnt_d      = CW'(WIDTH - 1);
        // opa_q keeps the raw dividend for the divide-by-zero result.
        if (is_div_q) begin
          acc_d = {{WIDTH{1'b0}}, a_mag};
          opb_d = b_mag;
        end else begin
          acc_d = {{WIDTH{1'b0}}, b_mag};
          opb_d = a_mag;
        end
        state_d = CALC;
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mult_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = product;
        end else if (div_zero_q) begin
          lo_d = '1;
          hi_d = opa_q;
        end else begin
          lo_d = quot;
          hi_d = rem;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    // Direct writes land regardless of flush and win over any result.
    if (hiWrite) hi_d = wData;
    if (loWrite) lo_d = wData;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed mult/div cases, aborts,
// reset mid-op, back-to-back issue and a randomized run against a 64-bit model.
module tb_hilo_md_unit;

  logic        clk;
  logic        rstN;
  logic        mult;
  logic        div;
  logic        isUnsigned;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] wData;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  hilo_md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .mult(mult), .div(div), .isUnsigned(isUnsigned),
    .opA(opA), .opB(opB), .flush(flush), .hiWrite(hiWrite), .loWrite(loWrite),
    .wData(wData), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input bit is_div, input bit is_uns,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int     ia, ib, q, r;
    if (!is_div) begin
      if (is_uns) return {32'b0, a} * {32'b0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (is_uns) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    ia = a;
    ib = b;
    q  = ia / ib;
    r  = ia % ib;
    return {r, q};
  endfunction

  // Driver: issue one op at the current negedge and wait (bounded) for done.
  task automatic run_op(input bit is_div, input bit is_uns, input logic [31:0] a,
                        input logic [31:0] b, output logic [63:0] got,
                        output int lat, output int busy_cnt);
    mult = !is_div; div = is_div; isUnsigned = is_uns; opA = a; opB = b;
    @(negedge clk);
    mult = 1'b0; div = 1'b0;
    lat = 0; busy_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    got = {hi, lo};
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done} !== 66'b0) begin
      errors++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b exp all zero", hi, lo, busy, done);
    end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_unsigned();
    logic [63:0] got, exp;
    int lat, bc;
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL multu_max got=%h exp=%h", got, exp);
    end
    checks++;
    if (lat !== 35) begin
      errors++; $display("FAIL multu_latency got=%0d exp=35", lat);
    end
    checks++;
    if (bc !== 34) begin
      errors++; $display("FAIL multu_busy_cycles got=%0d exp=34", bc);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL multu_done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_mult_signed();
    logic [63:0] got, exp;
    int lat, bc;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL mult_neg3x5 got=%h exp=%h", got, exp);
    end
    exp_q.push_back({32'h4000_0000, 32'h0});
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL mult_minxmin got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_div();
    logic [63:0] got, exp;
    int lat, bc;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL div_neg7_2 got=%h exp=%h", got, exp);
    end
    exp_q.push_back({32'h1, 32'h3});
    run_op(1'b1, 1'b1, 32'h7, 32'h2, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL divu_7_2 got=%h exp=%h", got, exp);
    end
    checks++;
    if (lat !== 35) begin
      errors++; $display("FAIL divu_latency got=%0d exp=35", lat);
    end
    exp_q.push_back({32'h1, 32'hFFFF_FFFD});
    run_op(1'b1, 1'b0, 32'h7, 32'hFFFF_FFFE, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL div_7_neg2 got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_div_special();
    logic [63:0] got, exp;
    int lat, bc;
    exp_q.push_back({32'h1234, 32'hFFFF_FFFF});
    run_op(1'b1, 1'b1, 32'h1234, 32'h0, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL divu_by_zero got=%h exp=%h", got, exp);
    end
    checks++;
    if (lat !== 35) begin
      errors++; $display("FAIL div0_latency got=%0d exp=35", lat);
    end
    exp_q.push_back({32'h0, 32'h8000_0000});
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL div_min_neg1 got=%h exp=%h", got, exp);
    end
    exp_q.push_back({32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL div_signed_by_zero got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_abort();
    logic [63:0] exp;
    int dn;
    hiWrite = 1'b1; wData = 32'hAA;
    @(negedge clk);
    hiWrite = 1'b0; loWrite = 1'b1; wData = 32'hBB;
    @(negedge clk);
    loWrite = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      exp = (pass == 0) ? {32'hAA, 32'hBB} : {32'hCC, 32'hBB};
      mult = 1'b1; isUnsigned = 1'b0; opA = 32'h3; opB = 32'h5;
      @(negedge clk);
      mult = 1'b0;
      repeat (9) @(negedge clk);
      if (pass == 0) flush = 1'b1;
      else begin
        hiWrite = 1'b1; wData = 32'hCC;
      end
      @(negedge clk);
      flush = 1'b0; hiWrite = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL abort%0d_busy got=%b exp=0", pass, busy);
      end
      checks++;
      if ({hi, lo} !== exp) begin
        errors++; $display("FAIL abort%0d_hilo got=%h exp=%h", pass, {hi, lo}, exp);
      end
      dn = 0;
      repeat (40) begin
        if (done) dn++;
        @(negedge clk);
      end
      checks++;
      if (dn !== 0 || {hi, lo} !== exp) begin
        errors++; $display("FAIL abort%0d_late got done_cnt=%0d hilo=%h exp 0 %h", pass, dn, {hi, lo}, exp);
      end
    end
  endtask

  task automatic test_write_start();
    logic [63:0] got, exp;
    int lat, bc;
    hiWrite = 1'b1; loWrite = 1'b1; wData = 32'h55;
    mult = 1'b1; isUnsigned = 1'b1; opA = 32'h2; opB = 32'h3;
    @(negedge clk);
    hiWrite = 1'b0; loWrite = 1'b0; mult = 1'b0;
    checks++;
    if ({hi, lo, busy} !== {32'h55, 32'h55, 1'b1}) begin
      errors++; $display("FAIL write_with_start got hi=%h lo=%h busy=%b exp 55 55 1", hi, lo, busy);
    end
    exp_q.push_back({32'h0, 32'h6});
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    got = {hi, lo};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== 35) begin
      errors++; $display("FAIL write_then_result got=%h lat=%0d exp=%h lat=35", got, lat, exp);
    end
    flush = 1'b1; mult = 1'b1; hiWrite = 1'b1; wData = 32'h77;
    @(negedge clk);
    flush = 1'b0; mult = 1'b0; hiWrite = 1'b0;
    checks++;
    if ({hi, busy} !== {32'h77, 1'b0}) begin
      errors++; $display("FAIL flush_start_write got hi=%h busy=%b exp 77 0", hi, busy);
    end
    bc = 0;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] got, exp;
    int lat;
    div = 1'b1; isUnsigned = 1'b0; opA = 32'h7; opB = 32'h2;
    @(negedge clk);
    div = 1'b0;
    repeat (19) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, hi, lo, done} !== 66'b0) begin
      errors++; $display("FAIL reset_mid_div got busy=%b hi=%h lo=%h done=%b exp all zero", busy, hi, lo, done);
    end
    rstN = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'h0, 32'hC});
    mult = 1'b1; isUnsigned = 1'b1; opA = 32'h3; opB = 32'h4;
    @(negedge clk);
    mult = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (n == 5) begin
        div = 1'b1; isUnsigned = 1'b0; opA = 32'd100; opB = 32'd7;
      end
      if (n == 6) div = 1'b0;
      @(negedge clk);
    end
    got = {hi, lo};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== 35) begin
      errors++; $display("FAIL start_while_busy got=%h lat=%0d exp=%h lat=35", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    int lat, bc;
    exp_q.push_back(model(1'b0, 1'b0, 32'hFFFF_FF00, 32'h0001_0001));
    exp_q.push_back(model(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234));
    run_op(1'b0, 1'b0, 32'hFFFF_FF00, 32'h0001_0001, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_first got=%h exp=%h", got, exp);
    end
    run_op(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, got, lat, bc);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== 35) begin
      errors++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=35", got, lat, exp);
    end
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    logic [31:0] a, b;
    bit is_div, is_uns;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      is_div = $urandom_range(0, 1);
      is_uns = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = -32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      exp_q.push_back(model(is_div, is_uns, a, b));
      run_op(is_div, is_uns, a, b, got, lat, bc);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat !== 35) begin
        errors++;
        $display("FAIL random%0d div=%b uns=%b a=%h b=%h got=%h lat=%0d exp=%h lat=35",
                 i, is_div, is_uns, a, b, got, lat, exp);
      end
    end
  endtask

  initial begin
    rstN = 1'b0; mult = 1'b0; div = 1'b0; isUnsigned = 1'b0;
    opA = '0; opB = '0; flush = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; wData = '0;
    @(negedge clk);
    test_reset();
    test_mult_unsigned();
    test_mult_signed();
    test_div();
    test_div_special();
    test_abort();
    test_write_start();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
